// File: rtl/bp_be_pkg.sv
// Shared backend FP types: writeback entry, shadow tag, fflags and precision.
package bp_be_pkg;

    localparam int reg_addr_width_gp = 5;

    typedef struct packed {
        logic nv;
        logic dz;
        logic of;
        logic uf;
        logic nx;
    } rv64_fflags_s;

    typedef enum logic {
        e_pr_single = 1'b0,
        e_pr_double = 1'b1
    } bp_be_fp_pr_e;

    typedef struct packed {
        logic [reg_addr_width_gp-1:0] rd;
        logic [63:0]                  data;
        rv64_fflags_s                 eflags;
    } bp_be_fp_wb_entry_s;

    typedef struct packed {
        logic                         v;
        logic [reg_addr_width_gp-1:0] rd;
        bp_be_fp_pr_e                 opr;
    } bp_be_fp_shadow_s;

    // Pointer width that stays legal for a single-entry structure.
    function automatic int bp_be_safe_clog2(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/bp_be_fp_shadow_chain.sv
// Valid/tag delay line matching a fixed-latency datapath; clear drops all valids.
module bp_be_fp_shadow_chain #(
    parameter int stages_p = 1,
    parameter int width_p  = 1
) (
    input  logic               clk_i,
    input  logic               reset_i,
    input  logic               clear_i,
    input  logic               v_i,
    input  logic [width_p-1:0] tag_i,
    output logic               v_o,
    output logic [width_p-1:0] tag_o
);

    logic [stages_p:1]              vld_pipe;
    logic [stages_p:1][width_p-1:0] tag_pipe;

    // Tags need no reset: they are only observed alongside a set valid.
    always_ff @(posedge clk_i) begin
        if (reset_i | clear_i) begin
            vld_pipe <= '0;
        end else begin
            vld_pipe[1] <= v_i;
            for (int i = 2; i <= stages_p; i++)
                vld_pipe[i] <= vld_pipe[i-1];
        end
        tag_pipe[1] <= tag_i;
        for (int i = 2; i <= stages_p; i++)
            tag_pipe[i] <= tag_pipe[i-1];
    end

    assign v_o   = vld_pipe[stages_p];
    assign tag_o = tag_pipe[stages_p];

endmodule

// File: rtl/bsg_mem_1r1w.sv
// One write port, one asynchronous read port register-file storage.
module bsg_mem_1r1w
    import bp_be_pkg::*;
#(
    parameter int width_p = 8,
    parameter int els_p   = 4,
    parameter int addr_width_lp = bp_be_safe_clog2(els_p)
) (
    input  logic                     w_clk_i,
    input  logic                     w_v_i,
    input  logic [addr_width_lp-1:0] w_addr_i,
    input  logic [width_p-1:0]       w_data_i,
    input  logic [addr_width_lp-1:0] r_addr_i,
    output logic [width_p-1:0]       r_data_o
);

    logic [width_p-1:0] mem [els_p];

    always_ff @(posedge w_clk_i) begin
        if (w_v_i)
            mem[w_addr_i] <= w_data_i;
    end

    assign r_data_o = mem[r_addr_i];

endmodule

// File: rtl/bp_be_fpu_aux_wb_queue.sv
// Writeback queue behind the fixed-latency aux FPU pipe: shadow tags, credit
// flow control, in-order result queue and sticky fflags accumulation.
module bp_be_fpu_aux_wb_queue
    import bp_be_pkg::*;
#(
    parameter int latency_p        = 2,
    parameter int depth_p          = 4,
    parameter int reg_addr_width_p = reg_addr_width_gp
) (
    input  logic                        clk_i,
    input  logic                        reset_i,
    input  logic                        issue_v_i,
    input  logic [reg_addr_width_p-1:0] issue_rd_i,
    input  bp_be_fp_pr_e                issue_opr_i,
    output logic                        issue_ready_o,
    input  logic                        flush_i,
    input  logic [63:0]                 result_i,
    input  rv64_fflags_s                eflags_i,
    output logic                        wb_v_o,
    output logic [reg_addr_width_p-1:0] wb_rd_o,
    output logic [63:0]                 wb_data_o,
    output rv64_fflags_s                wb_eflags_o,
    input  logic                        wb_yumi_i,
    input  logic                        fflags_clr_i,
    output rv64_fflags_s                fflags_o
);

    localparam int ptr_w = bp_be_safe_clog2(depth_p);
    localparam int cnt_w = $clog2(depth_p + 1);
    localparam int tag_w = $bits(bp_be_fp_shadow_s) - 1;
    localparam int ent_w = $bits(bp_be_fp_wb_entry_s);

    bp_be_fp_shadow_s   shadow_in, shadow_out;
    logic               shadow_v;
    logic [tag_w-1:0]   shadow_tag;
    bp_be_fp_wb_entry_s wr_entry, head;
    logic [ent_w-1:0]   head_raw;

    logic [cnt_w-1:0] cnt, qcnt;
    logic [ptr_w-1:0] wptr, rptr;
    logic             issue_fire, enq, deq;

    assign shadow_in = '{v: issue_v_i & ~flush_i, rd: issue_rd_i, opr: issue_opr_i};

    bp_be_fp_shadow_chain #(
        .stages_p(latency_p - 1),
        .width_p (tag_w)
    ) chain (
        .clk_i  (clk_i),
        .reset_i(reset_i),
        .clear_i(flush_i),
        .v_i    (shadow_in.v),
        .tag_i  ({shadow_in.rd, shadow_in.opr}),
        .v_o    (shadow_v),
        .tag_o  (shadow_tag)
    );

    assign shadow_out = bp_be_fp_shadow_s'({shadow_v, shadow_tag});

    // Credits cover in-flight plus queued ops, so enqueue never needs backpressure.
    assign issue_ready_o = (cnt < cnt_w'(depth_p));
    assign issue_fire    = issue_v_i & issue_ready_o;
    assign enq           = shadow_out.v & ~flush_i;
    assign deq           = wb_yumi_i & ~flush_i;

    always_ff @(posedge clk_i) begin
        if (reset_i | flush_i) begin
            cnt  <= '0;
            qcnt <= '0;
            wptr <= '0;
            rptr <= '0;
        end else begin
            cnt  <= cnt + cnt_w'(issue_fire) - cnt_w'(wb_yumi_i);
            qcnt <= qcnt + cnt_w'(enq) - cnt_w'(deq);
            if (enq)
                wptr <= (wptr == ptr_w'(depth_p - 1)) ? '0 : wptr + ptr_w'(1);
            if (deq)
                rptr <= (rptr == ptr_w'(depth_p - 1)) ? '0 : rptr + ptr_w'(1);
        end
    end

    assign wr_entry = '{rd: shadow_out.rd, data: result_i, eflags: eflags_i};

    bsg_mem_1r1w #(
        .width_p(ent_w),
        .els_p  (depth_p)
    ) mem (
        .w_clk_i (clk_i),
        .w_v_i   (enq),
        .w_addr_i(wptr),
        .w_data_i(wr_entry),
        .r_addr_i(rptr),
        .r_data_o(head_raw)
    );

    assign head        = bp_be_fp_wb_entry_s'(head_raw);
    assign wb_v_o      = (qcnt != '0);
    assign wb_rd_o     = head.rd;
    assign wb_data_o   = head.data;
    assign wb_eflags_o = head.eflags;

    always_ff @(posedge clk_i) begin
        if (reset_i)
            fflags_o <= '0;
        else if (fflags_clr_i)
            fflags_o <= deq ? wb_eflags_o : '0;
        else if (deq)
            fflags_o <= rv64_fflags_s'(fflags_o | wb_eflags_o);
    end

`ifndef SYNTHESIS
    a_latency: assert property (@(posedge clk_i) latency_p >= 2);
    a_issue:   assert property (@(posedge clk_i) disable iff (reset_i) issue_v_i |-> issue_ready_o);
    a_yumi:    assert property (@(posedge clk_i) disable iff (reset_i) wb_yumi_i |-> wb_v_o);
    a_full:    assert property (@(posedge clk_i) disable iff (reset_i)
                                enq |-> (qcnt != cnt_w'(depth_p)) || deq);
    a_nanbox:  assert property (@(posedge clk_i) disable iff (reset_i)
                                (enq && shadow_out.opr == e_pr_single) |-> (result_i[63:32] == 32'hffff_ffff));
`endif

endmodule

// File: tb/tb_bp_be_fpu_aux_wb_queue.sv
// Directed scenarios then random traffic, compared against a queue-based model.
module tb_bp_be_fpu_aux_wb_queue;
    import bp_be_pkg::*;

    localparam int LAT   = 2;
    localparam int DEPTH = 4;

    logic         clk = 0;
    logic         reset_i;
    logic         issue_v_i;
    logic [4:0]   issue_rd_i;
    bp_be_fp_pr_e issue_opr_i;
    logic         issue_ready_o;
    logic         flush_i;
    logic [63:0]  result_i;
    rv64_fflags_s eflags_i;
    logic         wb_v_o;
    logic [4:0]   wb_rd_o;
    logic [63:0]  wb_data_o;
    rv64_fflags_s wb_eflags_o;
    logic         wb_yumi_i;
    logic         fflags_clr_i;
    rv64_fflags_s fflags_o;

    bp_be_fpu_aux_wb_queue #(
        .latency_p(LAT), .depth_p(DEPTH), .reg_addr_width_p(5)
    ) dut (
        .clk_i(clk), .reset_i(reset_i),
        .issue_v_i(issue_v_i), .issue_rd_i(issue_rd_i), .issue_opr_i(issue_opr_i),
        .issue_ready_o(issue_ready_o), .flush_i(flush_i),
        .result_i(result_i), .eflags_i(eflags_i),
        .wb_v_o(wb_v_o), .wb_rd_o(wb_rd_o), .wb_data_o(wb_data_o), .wb_eflags_o(wb_eflags_o),
        .wb_yumi_i(wb_yumi_i), .fflags_clr_i(fflags_clr_i), .fflags_o(fflags_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [4:0]  rd;
        logic [63:0] d;
        logic [4:0]  ef;
        int          due;
    } op_t;

    op_t        infl[$];
    op_t        wbq[$];
    int         cnt_m;
    logic [4:0] ff_m;
    int         cyc;
    int         n_vec, n_err;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s (cycle %0d): got %h expected %h", tag, cyc, obs, exp);
        end
    endtask

    // Check outputs at negedge, drive this cycle's inputs, advance the model one edge.
    task automatic step(input bit iv, input logic [4:0] rd, input bit sp, input logic [63:0] d,
                        input logic [4:0] ef, input bit y, input bit fl, input bit clr);
        op_t o, h;
        bit  ivx, yx;
        chk("issue_ready", 64'(issue_ready_o), 64'(cnt_m < DEPTH));
        chk("wb_v", 64'(wb_v_o), 64'(wbq.size() != 0));
        if (wbq.size() != 0) begin
            chk("wb_rd", 64'(wb_rd_o), 64'(wbq[0].rd));
            chk("wb_data", wb_data_o, wbq[0].d);
            chk("wb_eflags", 64'(wb_eflags_o), 64'(wbq[0].ef));
        end
        chk("fflags", 64'(fflags_o), 64'(ff_m));

        ivx = iv && (cnt_m < DEPTH);
        yx  = y && (wbq.size() != 0);
        issue_v_i    = ivx;
        issue_rd_i   = rd;
        issue_opr_i  = sp ? e_pr_single : e_pr_double;
        wb_yumi_i    = yx;
        flush_i      = fl;
        fflags_clr_i = clr;
        if (infl.size() != 0 && infl[0].due == cyc) begin
            result_i = infl[0].d;
            eflags_i = rv64_fflags_s'(infl[0].ef);
        end else begin
            result_i = {$urandom(), $urandom()};
            eflags_i = rv64_fflags_s'(5'($urandom()));
        end

        if (fl) begin
            infl.delete();
            wbq.delete();
            cnt_m = 0;
            if (clr) ff_m = '0;
        end else begin
            if (yx) begin
                h = wbq.pop_front();
                ff_m = clr ? h.ef : (ff_m | h.ef);
            end else if (clr) begin
                ff_m = '0;
            end
            if (infl.size() != 0 && infl[0].due == cyc)
                wbq.push_back(infl.pop_front());
            if (ivx) begin
                o.rd  = rd;
                o.d   = sp ? {32'hffff_ffff, d[31:0]} : d;
                o.ef  = ef;
                o.due = cyc + LAT - 1;
                infl.push_back(o);
            end
            cnt_m += int'(ivx) - int'(yx);
        end
        cyc++;
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        n_vec = 0; n_err = 0; cyc = 0; cnt_m = 0; ff_m = '0;
        reset_i = 1; issue_v_i = 0; issue_rd_i = 0; issue_opr_i = e_pr_double;
        flush_i = 0; result_i = 0; eflags_i = '0; wb_yumi_i = 0; fflags_clr_i = 0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset_i = 0;

        // single op: rd=3, data on the next cycle, visible two cycles after issue
        step(1, 5'd3, 0, 64'h4000_0000_0000_0000, 5'b00001, 0, 0, 0);
        idle(2);
        step(0, 0, 0, 0, 0, 1, 0, 0);
        idle(1);

        // fill with yumi low, one pop, then drain and wrap the pointers
        for (int i = 0; i < 4; i++)
            step(1, 5'(i), i[0], {$urandom(), $urandom()}, 5'($urandom()), 0, 0, 0);
        idle(4);
        step(0, 0, 0, 0, 0, 1, 0, 0);
        idle(1);
        for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 0, 1, 0, 0);
        for (int i = 0; i < 5; i++)
            step(1, 5'(4 + i), i[0], {$urandom(), $urandom()}, 5'($urandom()), 1, 0, 0);
        idle(3);

        // near-full: issue and yumi together every cycle
        for (int i = 0; i < 3; i++)
            step(1, 5'(10 + i), 0, {$urandom(), $urandom()}, 5'($urandom()), 0, 0, 0);
        for (int i = 0; i < 8; i++)
            step(1, 5'(13 + i), i[0], {$urandom(), $urandom()}, 5'($urandom()), 1, 0, 0);
        for (int i = 0; i < 6; i++) step(0, 0, 0, 0, 0, 1, 0, 0);

        // flush with two queued, one in flight and a concurrent issue
        step(1, 5'd20, 0, 64'h1111, 5'b00010, 0, 0, 0);
        step(1, 5'd21, 0, 64'h2222, 5'b00100, 0, 0, 0);
        idle(2);
        step(1, 5'd22, 0, 64'h3333, 5'b01000, 0, 0, 0);
        step(1, 5'd23, 0, 64'h4444, 5'b10000, 0, 1, 0);
        idle(3);

        // fflags clear priority
        step(0, 0, 0, 0, 0, 0, 0, 1);
        step(1, 5'd24, 0, 64'h5555, 5'b10000, 0, 0, 0);
        idle(2);
        step(0, 0, 0, 0, 0, 1, 0, 0);
        step(1, 5'd25, 0, 64'h6666, 5'b00100, 0, 0, 0);
        idle(2);
        step(0, 0, 0, 0, 0, 1, 0, 1);
        step(0, 0, 0, 0, 0, 0, 0, 1);
        idle(1);

        // random traffic in alternating fill/drain phases
        for (int k = 0; k < 3000; k++) begin
            int  pi, py;
            bit  fl, clr;
            pi  = ((k / 300) % 2 == 0) ? 80 : 35;
            py  = ((k / 300) % 2 == 0) ? 30 : 85;
            fl  = ($urandom_range(0, 99) < 2);
            clr = !fl && ($urandom_range(0, 99) < 3);
            step($urandom_range(0, 99) < pi, 5'($urandom()), 1'($urandom_range(0, 1)),
                 {$urandom(), $urandom()}, 5'($urandom()), $urandom_range(0, 99) < py, fl, clr);
        end
        idle(4);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
